// File: rtl/fsm_input_cond_pkg.sv
// Shared encodings and helpers for the two-channel input conditioner.
package fsm_input_cond_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] HOLD_A = 2'b01;
  localparam logic [1:0] HOLD_B = 2'b10;

  localparam logic [7:0] STAT_SAT = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == STAT_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fsm_input_cond_debounce_ch.sv
// One conditioner channel: multi-flop synchronizer, counting debouncer and
// rising-edge detector on the debounced level.
module input_debounce_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   lvl_dly_q;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // synchronizer chain, bit 0 is the metastability-exposed stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  // accept a new level only after DB_CYCLES consecutive differing samples
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (sync_s != lvl_q) begin
      if (cnt_q == DB_LAST) begin
        lvl_d = ~lvl_q;
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // debounce state and delayed level for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = lvl_q & ~lvl_dly_q;

endmodule

// File: rtl/fsm_input_cond.sv
// Two-channel input conditioner with a pairing FSM that merges near-coincident
// rises. Optional INPUT_COND_STAT_EN adds saturating pair/solo event counters.
module fsm_input_cond
  import fsm_input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int WINDOW      = 3,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_raw,
  input  logic       b_raw,
  output logic       a,
  output logic       b,
  output logic       a_lvl,
  output logic       b_lvl,
  output logic       busy
`ifdef INPUT_COND_STAT_EN
  ,
  output logic [7:0] pair_cnt,
  output logic [7:0] solo_cnt
`endif
);

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  logic             rise_a_s, rise_b_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q;

  input_debounce_ch #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_ch_a (
    .clk   (clk),
    .rst   (rst),
    .raw_i (a_raw),
    .lvl_o (a_lvl),
    .rise_o(rise_a_s)
  );

  input_debounce_ch #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_ch_b (
    .clk   (clk),
    .rst   (rst),
    .raw_i (b_raw),
    .lvl_o (b_lvl),
    .rise_o(rise_b_s)
  );

  // pairing state, window counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= {CNT_W{1'b0}};
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // next state: a held rise waits up to WINDOW cycles for its partner
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        win_d = {CNT_W{1'b0}};
        if (rise_a_s & rise_b_s) begin
          state_d = IDLE;
        end else if (rise_a_s) begin
          state_d = HOLD_A;
        end else if (rise_b_s) begin
          state_d = HOLD_B;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD_A: begin
        if (rise_b_s) begin
          state_d = IDLE;
          win_d   = {CNT_W{1'b0}};
        end else if (rise_a_s) begin
          win_d = {CNT_W{1'b0}};
        end else if (win_q == WIN_LAST) begin
          state_d = IDLE;
          win_d   = {CNT_W{1'b0}};
        end else begin
          win_d = win_q + CNT_W'(1);
        end
      end
      HOLD_B: begin
        if (rise_a_s) begin
          state_d = IDLE;
          win_d   = {CNT_W{1'b0}};
        end else if (rise_b_s) begin
          win_d = {CNT_W{1'b0}};
        end else if (win_q == WIN_LAST) begin
          state_d = IDLE;
          win_d   = {CNT_W{1'b0}};
        end else begin
          win_d = win_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        win_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // outputs: a repeated own-channel rise flushes the held one as a solo event
  always_comb begin
    a_d = 1'b0;
    b_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_a_s & rise_b_s) begin
          a_d = 1'b1;
          b_d = 1'b1;
        end else begin
          a_d = 1'b0;
          b_d = 1'b0;
        end
      end
      HOLD_A: begin
        if (rise_b_s) begin
          a_d = 1'b1;
          b_d = 1'b1;
        end else if (rise_a_s || (win_q == WIN_LAST)) begin
          a_d = 1'b1;
        end else begin
          a_d = 1'b0;
        end
      end
      HOLD_B: begin
        if (rise_a_s) begin
          a_d = 1'b1;
          b_d = 1'b1;
        end else if (rise_b_s || (win_q == WIN_LAST)) begin
          b_d = 1'b1;
        end else begin
          b_d = 1'b0;
        end
      end
      default: begin
        a_d = 1'b0;
        b_d = 1'b0;
      end
    endcase
  end

  assign a    = a_q;
  assign b    = b_q;
  assign busy = busy_q;

`ifdef INPUT_COND_STAT_EN
  logic [7:0] pair_q, solo_q;

  // saturating event statistics, counted on the emitted pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_q <= 8'd0;
      solo_q <= 8'd0;
    end else begin
      if (a_d & b_d) begin
        pair_q <= sat_inc(pair_q);
      end else begin
        pair_q <= pair_q;
      end
      if (a_d ^ b_d) begin
        solo_q <= sat_inc(solo_q);
      end else begin
        solo_q <= solo_q;
      end
    end
  end

  assign pair_cnt = pair_q;
  assign solo_cnt = solo_q;
`endif

endmodule

// File: doc/fsm_input_cond.md
Name: fsm_input_cond

Overview:
Two-channel input conditioner that sits directly upstream of the a/b-driven control FSM. Takes asynchronous raw inputs a_raw/b_raw and, per channel, synchronizes, debounces and rising-edge-detects them. A pairing state machine then merges near-coincident rises so the downstream FSM sees a and b asserted in the same cycle. Outputs a/b are registered single-cycle pulses.

Parameters:
SYNC_STAGES, 2, synchronizer flop depth per channel (>=2)
DB_CYCLES, 4, consecutive stable synchronized samples required to accept a new level (>=1)
WINDOW, 3, cycles a lone rise is held waiting for the other channel (>=1)
CNT_W, 4, width of debounce/window counters; must hold max(DB_CYCLES, WINDOW)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
a_raw  in  1  raw asynchronous input A
b_raw  in  1  raw asynchronous input B
a  out  1  conditioned A pulse to downstream FSM
b  out  1  conditioned B pulse to downstream FSM
a_lvl  out  1  debounced level of A
b_lvl  out  1  debounced level of B
busy  out  1  high while a lone rise is held (state != IDLE)

Behaviour:
- Reset (rst low, any time, async): all sync flops, debounced levels, counters and state cleared; a=b=a_lvl=b_lvl=busy=0; state IDLE. A rise held at reset is discarded.
- Sync: SYNC_STAGES-flop chain per channel, reset value 0.
- Debounce: counter increments each cycle the sync output != lvl and clears when equal. lvl flips on the edge completing DB_CYCLES consecutive differing samples; counter clears on flip. Pulses shorter than DB_CYCLES sync cycles are filtered.
- Edge: rise_x = lvl_x & ~lvl_x_d (combinational, one cycle). Falling edges generate no output.
- Latency: N = SYNC_STAGES + DB_CYCLES. Edge k=1 is the first edge sampling the new raw level. lvl changes at edge N. A simultaneous pair pulse appears at edge N+1.
- Pairing FSM, states IDLE, HOLD_A, HOLD_B, window counter win:
  IDLE: rise_a&rise_b -> a=b=1 next cycle, stay IDLE. rise_a only -> HOLD_A, win=0. rise_b only -> HOLD_B, win=0.
  HOLD_A: rise_b -> a=b=1, IDLE. Else rise_a again -> a=1 alone (emits the held rise), win=0, stay HOLD_A. Else win==WINDOW-1 -> a=1 alone, IDLE. Else win++.
  HOLD_B: symmetric to HOLD_A.
- A lone rise therefore emits at edge N+1+WINDOW. a/b are never high more than one consecutive cycle, except during back-to-back events, which are separated by at least DB_CYCLES.
- busy = (state != IDLE), registered with state.
- Downstream contract: a&b high together only via pairing. The consumer treats a alone and b alone as distinct events.

Optional Feature:
Macro INPUT_COND_STAT_EN.
- Defined: adds outputs pair_cnt[7:0] and solo_cnt[7:0]. These are saturating counts (stick at 255) of paired emissions and lone emissions. Async reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package fsm_input_cond_pkg holds the state encoding localparams IDLE=2'b00, HOLD_A=2'b01, HOLD_B=2'b10, and the counter saturation constant.
- Sub-module input_debounce_ch contains sync + debounce + rise detect for one channel, parameterized SYNC_STAGES/DB_CYCLES/CNT_W. It is instantiated twice; the pairing FSM stays in the top.

Test Plan:
(defaults SYNC=2, DB=4, WINDOW=3, N=6)
- Reset: hold rst low with a_raw=b_raw=1 -> all outputs 0. Release -> a_lvl/b_lvl rise at edge 6 after release; a=b=1 single cycle at edge 7.
- Glitch: a_raw high 3 cycles then low -> a_lvl never rises; a never pulses; busy stays 0.
- Near-coincident: a_raw rises, b_raw rises 2 cycles later -> busy high from edge 7; a=b=1 together at edge 9; busy low after.
- Lone rise: a_raw rises, b_raw stays 0 -> a=1 alone at edge 10 (N+1+WINDOW), b=0 throughout.
- Reset mid-hold: a_raw rises, rst pulsed low at edge 8 -> a never pulses; busy=0 immediately on rst assertion.
- STAT_EN build: 300 paired events -> pair_cnt=255 saturated, solo_cnt=0.
